// File: rtl/softmax_outp_writer.sv
// rtl/softmax_outp_writer.sv - packs softmax lane results and writes them to output memory via a small FIFO
module softmax_outp_writer #(
  parameter int DATAWIDTH  = 16,
  parameter int NUM        = 4,
  parameter int ADDRSIZE   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDRSIZE-1:0]       addr_limit,
  input  logic [DATAWIDTH-1:0]      outp0,
  input  logic [DATAWIDTH-1:0]      outp1,
  input  logic [DATAWIDTH-1:0]      outp2,
  input  logic [DATAWIDTH-1:0]      outp3,
  input  logic                      outp_valid,
  output logic                      outp_ready,
  output logic                      wr_valid,
  input  logic                      wr_ready,
  output logic [ADDRSIZE-1:0]       wr_addr,
  output logic [DATAWIDTH*NUM-1:0]  wr_data,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = ADDRSIZE + 1;
  localparam int WW = DATAWIDTH * NUM;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]          state;
  logic [ADDRSIZE-1:0] lim;
  logic [CW-1:0]       in_cnt;
  logic [CW-1:0]       out_cnt;
  logic [CW-1:0]       last_cnt;
  logic [CW-1:0]       in_nxt;
  logic [CW-1:0]       out_nxt;
  logic [WW-1:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [PW:0]         count;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic [WW-1:0]       word_in;

  always_comb begin
    word_in    = {outp3, outp2, outp1, outp0};
    fifo_full  = (count == FULL_CNT);
    fifo_empty = (count == '0);
    // Counters are one bit wider than the address so lim=max still terminates.
    last_cnt   = {1'b0, lim} + CW'(1);
    outp_ready = (state == S_RUN) && !fifo_full && (in_cnt <= {1'b0, lim});
    push       = outp_valid && outp_ready;
    wr_valid   = !fifo_empty;
    pop        = wr_valid && wr_ready;
    in_nxt     = in_cnt + CW'(push);
    out_nxt    = out_cnt + CW'(pop);
    wr_addr    = out_cnt[ADDRSIZE-1:0];
    wr_data    = fifo_empty ? '0 : mem[rd_ptr];
    busy       = (state == S_RUN) || (state == S_DRAIN);
    done       = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      lim      <= '0;
      in_cnt   <= '0;
      out_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      in_cnt  <= in_nxt;
      out_cnt <= out_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            lim      <= addr_limit;
            in_cnt   <= '0;
            out_cnt  <= '0;
            overflow <= 1'b0;
            state    <= S_RUN;
          end else if (outp_valid) begin
            overflow <= 1'b1;
          end
        end
        S_RUN: begin
          if (push && (in_nxt == last_cnt)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (outp_valid) overflow <= 1'b1;
          // Also covers the case where the final write already landed in RUN.
          if (out_nxt == last_cnt) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_softmax_outp_writer.sv
// tb/tb_softmax_outp_writer.sv - directed self-checking bench for softmax_outp_writer
module tb_softmax_outp_writer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  addr_limit = '0;
  logic [15:0] outp0 = '0, outp1 = '0, outp2 = '0, outp3 = '0;
  logic        outp_valid = 1'b0;
  logic        outp_ready;
  logic        wr_valid;
  logic        wr_ready = 1'b0;
  logic [7:0]  wr_addr;
  logic [63:0] wr_data;
  logic        busy, done, overflow;

  softmax_outp_writer dut (
    .clk(clk), .reset(reset), .start(start), .addr_limit(addr_limit),
    .outp0(outp0), .outp1(outp1), .outp2(outp2), .outp3(outp3),
    .outp_valid(outp_valid), .outp_ready(outp_ready),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  logic [63:0] words [256];
  int fidx = 0;
  int done_base = 0;
  int wr_base = 0;
  bit rnd_ready = 1'b0;

  logic [7:0]  got_addr [$];
  logic [63:0] got_data [$];
  int done_cnt = 0;
  int neg_cyc = 0;
  int last_wr_neg = 0;
  int done_neg = 0;

  always @(negedge clk) begin
    neg_cyc++;
    if (reset && wr_valid && wr_ready) begin
      got_addr.push_back(wr_addr);
      got_data.push_back(wr_data);
      last_wr_neg = neg_cyc;
    end
    if (done) begin
      done_cnt++;
      done_neg = neg_cyc;
    end
  end

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) wr_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic fill(int n, logic [15:0] tag);
    for (int i = 0; i < n; i++)
      words[i] = {16'(i) + 16'h3000, 16'(i) + 16'h2000, 16'(i) + 16'h1000, 16'(i)} ^ {4{tag}};
  endtask

  task automatic do_start(logic [7:0] lim);
    start = 1'b1;
    addr_limit = lim;
    done_base = done_cnt;
    wr_base = got_addr.size();
    tick();
    start = 1'b0;
    fidx = 0;
  endtask

  task automatic feed(int target, int cycles, bit must);
    int b = 0;
    bit acc;
    while (fidx < target && b < cycles) begin
      {outp3, outp2, outp1, outp0} = words[fidx];
      outp_valid = 1'b1;
      acc = outp_ready;
      tick();
      if (acc) fidx++;
      b++;
    end
    outp_valid = 1'b0;
    if (must) check("feed_accepts", 64'(fidx), 64'(target));
  endtask

  task automatic wait_done(string tag, int budget);
    int b = 0;
    while (done_cnt == done_base && b < budget) begin
      tick();
      b++;
    end
    tick();
    tick();
    check({tag, "_done_once"}, 64'(done_cnt - done_base), 64'd1);
  endtask

  task automatic check_writes(string tag, int n);
    check({tag, "_nwrites"}, 64'(got_addr.size() - wr_base), 64'(n));
    for (int i = 0; i < n && wr_base + i < got_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(got_addr[wr_base + i]), 64'(i));
      check($sformatf("%s_data%0d", tag, i), got_data[wr_base + i], words[i]);
    end
  endtask

  initial begin
    int aerr;
    int derr;
    tick();
    check("rst_outp_ready", 64'(outp_ready), 64'd0);
    check("rst_wr", {wr_data[55:0], wr_addr} , 64'd0);
    check("rst_flags", 64'({wr_valid, busy, done, overflow}), 64'd0);
    reset = 1'b1;
    tick();

    // Basic run, packing and done timing
    words[0] = 64'h993e_4210_4040_3800;
    words[1] = 64'h0004_0003_0002_0001;
    words[2] = 64'hfbff_7bff_0000_ffff;
    wr_ready = 1'b1;
    do_start(8'd2);
    check("basic_busy", 64'(busy), 64'd1);
    feed(3, 10, 1'b1);
    wait_done("basic", 20);
    check_writes("basic", 3);
    check("basic_done_lag", 64'(done_neg - last_wr_neg), 64'd1);
    check("basic_busy_end", 64'(busy), 64'd0);

    // Idle overflow, then single-word run
    fill(2, 16'h5a5a);
    {outp3, outp2, outp1, outp0} = words[0];
    outp_valid = 1'b1;
    tick();
    tick();
    outp_valid = 1'b0;
    check("idle_wr_valid", 64'(wr_valid), 64'd0);
    check("idle_overflow", 64'(overflow), 64'd1);
    do_start(8'd0);
    check("start_clears_ovf", 64'(overflow), 64'd0);
    feed(1, 5, 1'b1);
    {outp3, outp2, outp1, outp0} = words[1];
    outp_valid = 1'b1;
    check("single_second_ready", 64'(outp_ready), 64'd0);
    tick();
    outp_valid = 1'b0;
    wait_done("single", 20);
    check_writes("single", 1);

    // Backpressure: FIFO fills after four accepts, head held stable
    fill(8, 16'h0f0f);
    wr_ready = 1'b0;
    do_start(8'd7);
    feed(8, 8, 1'b0);
    check("bp_accepts", 64'(fidx), 64'd4);
    check("bp_ready_low", 64'(outp_ready), 64'd0);
    tick();
    tick();
    check("bp_hold_valid", 64'(wr_valid), 64'd1);
    check("bp_hold_addr", 64'(wr_addr), 64'd0);
    check("bp_hold_data", wr_data, words[0]);
    wr_ready = 1'b1;
    feed(8, 40, 1'b1);
    wait_done("bp", 40);
    check_writes("bp", 8);

    // Reset mid-run aborts without done
    fill(6, 16'hdead);
    wr_ready = 1'b0;
    do_start(8'd5);
    feed(3, 10, 1'b1);
    reset = 1'b0;
    #1;
    check("mid_rst_wr_valid", 64'(wr_valid), 64'd0);
    check("mid_rst_wr", {wr_data[55:0], wr_addr}, 64'd0);
    check("mid_rst_flags", 64'({outp_ready, busy, done, overflow}), 64'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("mid_rst_no_done", 64'(done_cnt - done_base), 64'd0);
    fill(2, 16'h1234);
    wr_ready = 1'b1;
    do_start(8'd1);
    feed(2, 10, 1'b1);
    wait_done("after_rst", 20);
    check_writes("after_rst", 2);

    // Full address range with random backpressure
    fill(256, 16'h8421);
    rnd_ready = 1'b1;
    do_start(8'd255);
    feed(256, 3000, 1'b1);
    wait_done("full", 3000);
    rnd_ready = 1'b0;
    wr_ready = 1'b0;
    check("full_nwrites", 64'(got_addr.size() - wr_base), 64'd256);
    aerr = 0;
    derr = 0;
    for (int i = 0; i < 256 && wr_base + i < got_addr.size(); i++) begin
      if (got_addr[wr_base + i] !== 8'(i)) aerr++;
      if (got_data[wr_base + i] !== words[i]) derr++;
    end
    check("full_addr_errs", 64'(aerr), 64'd0);
    check("full_data_errs", 64'(derr), 64'd0);
    check("full_idle", 64'({busy, wr_valid}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
